// File: rtl/hs_fifo.sv
// hs_fifo: parameterised ready/valid FIFO with a registered occupancy counter.
// Sits behind a skid buffer to absorb bursts while the consumer stalls.
// in_ready and out_valid come only from registered state, so neither side
// sees a combinational path from the other side's handshake.
// DEPTH must be a power of two >= 2 so the pointers wrap for free.
module hs_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk_core,
    input  logic                       rst_core,
    input  logic                       flush_req,
    output logic                       stall,
    input  logic [WIDTH-1:0]           in,
    output logic                       in_ready,
    input  logic                       in_valid,
    output logic [WIDTH-1:0]           out,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Handshake: a word transfers on a rising clk_core edge exactly when
    // valid and ready are both high in that cycle; the sender holds its
    // payload and valid stable until that happens. During a flush cycle
    // both handshakes still show their usual values, but the flush wins
    // and any transfer in that cycle is cancelled.
    always_comb begin
        in_ready  = (count != FULL_COUNT);
        stall     = ~in_ready;
        out_valid = (count != '0);
        out       = mem[rd_ptr];
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Payload storage; left unreset because out is only meaningful with out_valid.
    always_ff @(posedge clk_core) begin
        if (push && !flush_req) begin
            mem[wr_ptr] <= in;
        end
    end

    // Pointer and occupancy update; flush overrides any push/pop this cycle.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/hs_fifo.md
Name: hs_fifo

Overview:
- Parameterised ready/valid FIFO that sits directly downstream of the core's skid buffers.
- Absorbs multi-cycle bursts when the consuming stage stalls, which decouples pipeline stages by more than one entry.
- Uses the same in/out handshake naming and flush semantics as the surrounding hs_utils blocks, so it can be chained behind a skid buffer without glue logic.

Parameters:
- WIDTH, 1, payload width in bits.
- DEPTH, 4, number of entries; must be a power of two and >= 2.

Ports:
- clk_core  input  1  core clock; all state updates on its rising edge.
- rst_core  input  1  reset: one clock; reset is asynchronous and active-high.
- flush_req  input  1  synchronous flush; empties the FIFO.
- stall  output  1  high when the FIFO is full (equal to ~in_ready).
- in  input  WIDTH  upstream payload.
- in_ready  output  1  FIFO can accept a word this cycle.
- in_valid  input  1  upstream payload valid.
- out  output  WIDTH  head-of-FIFO payload.
- out_ready  input  1  downstream accepts the head word.
- out_valid  output  1  head word valid.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Behaviour:
- Storage:
  - mem[DEPTH] of WIDTH bits.
  - wr_ptr and rd_ptr are each $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - count is a registered occupancy counter.
- Reset (rst_core high, asynchronous): wr_ptr=0, rd_ptr=0, count=0. Therefore out_valid=0, in_ready=1, stall=0. mem contents are not reset; out is don't-care while out_valid=0.
- Combinational outputs:
  - in_ready = (count != DEPTH).
  - stall = ~in_ready.
  - out_valid = (count != 0).
  - out = mem[rd_ptr].
- Transfer qualifiers:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Per clock edge, when not flushing:
  - push: mem[wr_ptr] <= in, wr_ptr <= wr_ptr+1.
  - pop: rd_ptr <= rd_ptr+1.
  - count: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Latency: a word pushed into an empty FIFO appears on out with out_valid=1 on the next cycle. There is no combinational in->out bypass.
- Throughput: one word per cycle sustained when 0 < count < DEPTH and both sides are active.
- Full: in_ready=0, so no push occurs. A pop in a full cycle sets in_ready=1 only in the following cycle; ready is not combinationally dependent on out_ready.
- Empty: out_valid=0, so no pop. A simultaneous push writes the entry, which becomes visible next cycle.
- Simultaneous push and pop at 0 < count < DEPTH: count unchanged, both pointers advance.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no loss or duplication.
- flush_req high at a clock edge:
  - wr_ptr=0, rd_ptr=0, count=0, regardless of push/pop in that cycle.
  - Flush has priority; any push that cycle is discarded.
  - Handshake outputs are not masked combinationally during the flush cycle; upstream and downstream must treat that cycle's transfers as cancelled.
- Reset asserted mid-operation: all state clears immediately (asynchronously). The first push after deassertion is accepted normally.
- in and in_valid are don't-care while in_ready=0. The upstream must hold in/in_valid stable until accepted, per team handshake rules.

Test Plan:
- Reset then idle: assert rst_core for 2 cycles, then release -> out_valid=0, in_ready=1, stall=0, count=0.
- Fill/drain, DEPTH=4: with out_ready=0, push 0xA,0xB,0xC,0xD -> count=4, in_ready=0, stall=1; a 5th in_valid is ignored. Then hold out_ready=1 -> out shows 0xA,0xB,0xC,0xD on consecutive cycles, then out_valid=0, count=0.
- Streaming with wrap: in_valid=1 and out_ready=1 continuously for 20 words (0..19) -> output sequence 0..19 in order, count stays at 1 after the first-cycle latency, pointers wrap 5 times.
- Full with simultaneous pop: FIFO full, out_ready=1 for one cycle while in_valid=1 -> that cycle in_ready=0 (no push), count becomes 3; next cycle in_ready=1 and the push is accepted.
- Flush: FIFO holds 3 words, assert flush_req for one cycle with in_valid=1 -> next cycle count=0, out_valid=0; the following push of 0x5 appears at out one cycle later.
- Async reset mid-stream: while streaming with count=2, pulse rst_core between clock edges -> out_valid drops immediately, count=0; after release, pushing 0x7 yields out=0x7 next cycle.
